// File: rtl/stage_mem_ctrl.sv
// Shared MIPS type package and the memory-access pipeline stage: DRAM req/ack
// handshake, byte-lane steering/sign extension, upstream stall and WB register.
package mips_abb_pkg;
  localparam int unsigned WIDTH_REG = 32;

  typedef logic [WIDTH_REG-1:0] reg_word_t;
  typedef logic [4:0]           reg_addr_t;
  typedef logic [31:0]          instr_addr_t;
  typedef logic [31:0]          dram_addr_t;
  typedef logic [31:0]          dram_data_t;

  typedef enum logic [2:0] {
    MEM_NONE    = 3'd0,
    MEM_B_LOAD  = 3'd1,
    MEM_W_LOAD  = 3'd2,
    MEM_B_STORE = 3'd3,
    MEM_W_STORE = 3'd4
  } memop_t;
endpackage

module stage_mem_ctrl
  import mips_abb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_i_valid,
  input  reg_word_t   mem_i_res,
  input  logic        mem_i_rfwe,
  input  reg_addr_t   mem_i_rfwa,
  input  memop_t      mem_i_memop,
  input  dram_addr_t  mem_i_mema,
  input  dram_data_t  mem_i_memd,
  input  instr_addr_t mem_i_pc,
  output logic        mem_o_stall,
  output logic        dram_req,
  output logic        dram_we,
  output logic [3:0]  dram_be,
  output dram_addr_t  dram_addr,
  output dram_data_t  dram_wdata,
  input  logic        dram_ack,
  input  dram_data_t  dram_rdata,
  output logic        wb_o_valid,
  output reg_word_t   wb_o_res,
  output logic        wb_o_rfwe,
  output reg_addr_t   wb_o_rfwa,
  output instr_addr_t wb_o_pc
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        is_mem, is_byte, is_store;
  logic        cap_rfwe, cap_byte, cap_store;
  reg_addr_t   cap_rfwa;
  instr_addr_t cap_pc;
  logic [1:0]  cap_lane;
  logic [7:0]  sel_byte;
  reg_word_t   load_res;

  assign is_mem   = mem_i_memop inside {MEM_B_LOAD, MEM_W_LOAD, MEM_B_STORE, MEM_W_STORE};
  assign is_byte  = mem_i_memop inside {MEM_B_LOAD, MEM_B_STORE};
  assign is_store = mem_i_memop inside {MEM_B_STORE, MEM_W_STORE};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_o_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_i_valid && is_mem) begin
          state_d     = ACCESS;
          mem_o_stall = 1'b1;
        end
      end
      ACCESS: begin
        if (dram_ack) state_d     = IDLE;
        else          mem_o_stall = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Upstream must never see a stall while the stage is being reset.
    if (!rst_n) mem_o_stall = 1'b0;
  end

  assign sel_byte = dram_rdata[{cap_lane, 3'b000} +: 8];

  always_comb begin
    load_res = '0;
    if (!cap_store) begin
      if (cap_byte) load_res = {{24{sel_byte[7]}}, sel_byte};
      else          load_res = dram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dram_req   <= 1'b0;
      dram_we    <= 1'b0;
      dram_be    <= '0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      wb_o_valid <= 1'b0;
      wb_o_res   <= '0;
      wb_o_rfwe  <= 1'b0;
      wb_o_rfwa  <= '0;
      wb_o_pc    <= '0;
      cap_rfwe   <= 1'b0;
      cap_rfwa   <= '0;
      cap_pc     <= '0;
      cap_lane   <= '0;
      cap_byte   <= 1'b0;
      cap_store  <= 1'b0;
    end else begin
      wb_o_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_i_valid && !is_mem) begin
            wb_o_valid <= 1'b1;
            wb_o_res   <= mem_i_res;
            wb_o_rfwe  <= mem_i_rfwe;
            wb_o_rfwa  <= mem_i_rfwa;
            wb_o_pc    <= mem_i_pc;
          end else if (mem_i_valid && is_mem) begin
            cap_rfwe   <= mem_i_rfwe;
            cap_rfwa   <= mem_i_rfwa;
            cap_pc     <= mem_i_pc;
            cap_lane   <= mem_i_mema[1:0];
            cap_byte   <= is_byte;
            cap_store  <= is_store;
            dram_req   <= 1'b1;
            dram_we    <= is_store;
            dram_be    <= is_byte ? (4'b0001 << mem_i_mema[1:0]) : 4'b1111;
            dram_addr  <= {mem_i_mema[31:2], 2'b00};
            dram_wdata <= is_byte ? {4{mem_i_memd[7:0]}} : mem_i_memd;
          end
        end
        ACCESS: begin
          if (dram_ack) begin
            dram_req   <= 1'b0;
            wb_o_valid <= 1'b1;
            wb_o_res   <= load_res;
            wb_o_rfwe  <= cap_rfwe;
            wb_o_rfwa  <= cap_rfwa;
            wb_o_pc    <= cap_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem_ctrl.sv
// Scoreboard bench for stage_mem_ctrl: expected WB bundles are queued when
// an instruction is driven and checked as wb_o_valid pulses appear.
module tb_stage_mem_ctrl;
  import mips_abb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_i_valid;
  reg_word_t   mem_i_res;
  logic        mem_i_rfwe;
  reg_addr_t   mem_i_rfwa;
  memop_t      mem_i_memop;
  dram_addr_t  mem_i_mema;
  dram_data_t  mem_i_memd;
  instr_addr_t mem_i_pc;
  logic        mem_o_stall;
  logic        dram_req, dram_we;
  logic [3:0]  dram_be;
  dram_addr_t  dram_addr;
  dram_data_t  dram_wdata;
  logic        dram_ack;
  dram_data_t  dram_rdata;
  logic        wb_o_valid, wb_o_rfwe;
  reg_word_t   wb_o_res;
  reg_addr_t   wb_o_rfwa;
  instr_addr_t wb_o_pc;

  typedef struct packed {
    logic [31:0] res;
    logic        rfwe;
    logic [4:0]  rfwa;
    logic [31:0] pc;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  stage_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_i_valid(mem_i_valid), .mem_i_res(mem_i_res),
    .mem_i_rfwe(mem_i_rfwe), .mem_i_rfwa(mem_i_rfwa), .mem_i_memop(mem_i_memop),
    .mem_i_mema(mem_i_mema), .mem_i_memd(mem_i_memd), .mem_i_pc(mem_i_pc),
    .mem_o_stall(mem_o_stall), .dram_req(dram_req), .dram_we(dram_we),
    .dram_be(dram_be), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_ack(dram_ack), .dram_rdata(dram_rdata), .wb_o_valid(wb_o_valid),
    .wb_o_res(wb_o_res), .wb_o_rfwe(wb_o_rfwe), .wb_o_rfwa(wb_o_rfwa),
    .wb_o_pc(wb_o_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // WB monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_o_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_unexpected: got res=%h rfwa=%0d pc=%h, expected no writeback",
                 wb_o_res, wb_o_rfwa, wb_o_pc);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if ({wb_o_res, wb_o_rfwe, wb_o_rfwa, wb_o_pc} !== e)
          $display("FAIL wb_bundle: got res=%h rfwe=%b rfwa=%0d pc=%h, expected res=%h rfwe=%b rfwa=%0d pc=%h",
                   wb_o_res, wb_o_rfwe, wb_o_rfwa, wb_o_pc, e.res, e.rfwe, e.rfwa, e.pc);
        else passes++;
      end
    end
  end

  task automatic idle_inputs();
    mem_i_valid = 1'b0;
    mem_i_memop = MEM_NONE;
    mem_i_res   = '0;
    mem_i_rfwe  = 1'b0;
    mem_i_rfwa  = '0;
    mem_i_mema  = '0;
    mem_i_memd  = '0;
    mem_i_pc    = '0;
    dram_ack    = 1'b0;
    dram_rdata  = '0;
  endtask

  // Starts and ends at a negedge with upstream idle.
  task automatic alu_op(input logic [31:0] res, input logic [4:0] rfwa, input logic [31:0] pc);
    mem_i_valid = 1'b1;
    mem_i_memop = MEM_NONE;
    mem_i_res   = res;
    mem_i_rfwe  = 1'b1;
    mem_i_rfwa  = rfwa;
    mem_i_pc    = pc;
    exp_q.push_back('{res: res, rfwe: 1'b1, rfwa: rfwa, pc: pc});
    #1;
    checks++;
    if (mem_o_stall !== 1'b0) $display("FAIL alu_stall: got %b, expected 0", mem_o_stall);
    else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic mem_op(input memop_t op, input logic [31:0] mema, input logic [31:0] memd,
                        input logic rfwe, input logic [4:0] rfwa, input logic [31:0] pc,
                        input int unsigned k, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_res);
    logic        exp_we;
    int unsigned stall_cnt;
    exp_we      = (op == MEM_B_STORE) || (op == MEM_W_STORE);
    stall_cnt   = 0;
    mem_i_valid = 1'b1;
    mem_i_memop = op;
    mem_i_res   = 32'hBAD0_BAD0;
    mem_i_rfwe  = rfwe;
    mem_i_rfwa  = rfwa;
    mem_i_mema  = mema;
    mem_i_memd  = memd;
    mem_i_pc    = pc;
    exp_q.push_back('{res: exp_res, rfwe: rfwe, rfwa: rfwa, pc: pc});
    #1;
    if (mem_o_stall === 1'b1) stall_cnt++;
    @(negedge clk);
    checks++;
    if ({dram_req, dram_we, dram_be, dram_addr, dram_wdata} !== {1'b1, exp_we, exp_be, exp_addr, exp_wdata})
      $display("FAIL dram_bundle: got req=%b we=%b be=%b addr=%h wdata=%h, expected req=1 we=%b be=%b addr=%h wdata=%h",
               dram_req, dram_we, dram_be, dram_addr, dram_wdata, exp_we, exp_be, exp_addr, exp_wdata);
    else passes++;
    for (int unsigned i = 0; i < k; i++) begin
      dram_ack = 1'b0;
      #1;
      if (mem_o_stall === 1'b1) stall_cnt++;
      @(negedge clk);
    end
    checks++;
    if ({dram_req, dram_be, dram_addr} !== {1'b1, exp_be, exp_addr})
      $display("FAIL dram_hold: got req=%b be=%b addr=%h, expected req=1 be=%b addr=%h",
               dram_req, dram_be, dram_addr, exp_be, exp_addr);
    else passes++;
    dram_ack   = 1'b1;
    dram_rdata = rdata;
    #1;
    checks++;
    if (mem_o_stall !== 1'b0) $display("FAIL ack_stall: got %b, expected 0", mem_o_stall);
    else passes++;
    checks++;
    if (stall_cnt != k + 1) $display("FAIL stall_len: got %0d cycles, expected %0d", stall_cnt, k + 1);
    else passes++;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (dram_req !== 1'b0) $display("FAIL req_drop: got %b, expected 0", dram_req);
    else passes++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dram_req, dram_we, dram_be, dram_addr, dram_wdata, wb_o_valid, wb_o_res, wb_o_rfwe, wb_o_rfwa, wb_o_pc} !== '0)
      $display("FAIL reset_outputs: got req=%b be=%b addr=%h wb_valid=%b wb_res=%h, expected all zero",
               dram_req, dram_be, dram_addr, wb_o_valid, wb_o_res);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_in_access();
    mem_i_valid = 1'b1;
    mem_i_memop = MEM_W_LOAD;
    mem_i_mema  = 32'h0000_0040;
    mem_i_rfwe  = 1'b1;
    mem_i_rfwa  = 5'd9;
    @(negedge clk);
    checks++;
    if (dram_req !== 1'b1) $display("FAIL access_req: got %b, expected 1", dram_req);
    else passes++;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_o_stall !== 1'b0) $display("FAIL reset_stall: got %b, expected 0", mem_o_stall);
    else passes++;
    checks++;
    if ({dram_req, dram_we, dram_be, dram_addr, dram_wdata, wb_o_valid} !== '0)
      $display("FAIL reset_abort: got req=%b be=%b addr=%h wb_valid=%b, expected all zero",
               dram_req, dram_be, dram_addr, wb_o_valid);
    else passes++;
    idle_inputs();
    rst_n      = 1'b1;
    dram_ack   = 1'b1;
    dram_rdata = 32'h1111_2222;
    @(negedge clk);
    dram_ack = 1'b0;
    checks++;
    if ({dram_req, wb_o_valid} !== 2'b00)
      $display("FAIL late_ack: got req=%b wb_valid=%b, expected 0 0", dram_req, wb_o_valid);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_alu_passthrough();
    alu_op(32'h1234_5678, 5'd5, 32'h0000_1000);
    alu_op(32'hCAFE_F00D, 5'd31, 32'h0000_1004);
    @(negedge clk);
  endtask

  task automatic test_word_load();
    mem_op(MEM_W_LOAD, 32'h0000_0104, 32'h0, 1'b1, 5'd7, 32'h0000_2000, 3,
           32'hDEAD_BEEF, 32'h0000_0104, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
  endtask

  task automatic test_byte_load();
    mem_op(MEM_B_LOAD, 32'h0000_0203, 32'h0, 1'b1, 5'd3, 32'h0000_3000, 1,
           32'h80FF_0011, 32'h0000_0200, 4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op(MEM_B_LOAD, 32'h0000_0201, 32'h0, 1'b1, 5'd4, 32'h0000_3004, 0,
           32'h80FF_0011, 32'h0000_0200, 4'b0010, 32'h0, 32'h0000_0000);
    mem_op(MEM_B_LOAD, 32'h0000_0200, 32'h0, 1'b1, 5'd6, 32'h0000_3008, 2,
           32'h80FF_0011, 32'h0000_0200, 4'b0001, 32'h0, 32'h0000_0011);
    mem_op(MEM_B_LOAD, 32'h0000_0202, 32'h0, 1'b1, 5'd8, 32'h0000_300C, 0,
           32'h80FF_0011, 32'h0000_0200, 4'b0100, 32'h0, 32'hFFFF_FFFF);
  endtask

  task automatic test_store();
    mem_op(MEM_B_STORE, 32'h0000_0012, 32'h0000_00A5, 1'b0, 5'd0, 32'h0000_4000, 1,
           32'hFFFF_FFFF, 32'h0000_0010, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    mem_op(MEM_W_STORE, 32'h0000_0107, 32'h1357_9BDF, 1'b0, 5'd0, 32'h0000_4004, 0,
           32'hFFFF_FFFF, 32'h0000_0104, 4'b1111, 32'h1357_9BDF, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    mem_op(MEM_W_LOAD, 32'h0000_0300, 32'h0, 1'b1, 5'd10, 32'h0000_5000, 0,
           32'h0BAD_F00D, 32'h0000_0300, 4'b1111, 32'h0, 32'h0BAD_F00D);
    alu_op(32'h0000_00AA, 5'd11, 32'h0000_5004);
    checks++;
    if (dram_req !== 1'b0) $display("FAIL dup_req: got %b, expected 0", dram_req);
    else passes++;
    mem_op(MEM_W_LOAD, 32'h0000_0304, 32'h0, 1'b1, 5'd12, 32'h0000_5008, 0,
           32'h7777_8888, 32'h0000_0304, 4'b1111, 32'h0, 32'h7777_8888);
    mem_op(MEM_B_STORE, 32'h0000_0305, 32'h0000_0033, 1'b0, 5'd0, 32'h0000_500C, 0,
           32'h0, 32'h0000_0304, 4'b0010, 32'h3333_3333, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_passthrough();
    test_word_load();
    test_byte_load();
    test_store();
    test_back_to_back();
    test_reset_in_access();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL wb_missing: got %0d outstanding, expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
